// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

  localparam int ADDR_W_D = 32;
  localparam int DATA_W_D = 128;

  localparam logic ARB_INST = 1'b0;
  localparam logic ARB_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT_RD
  } arb_state_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner select for the memory bus arbiter.
// MEM_ARB_RR_EN: round-robin with a last-served pointer; else data wins ties.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_inst,
  input  logic req_data,
  input  logic accept,
  input  logic owner,
  output logic winner
);

`ifdef MEM_ARB_RR_EN
  logic last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= ARB_INST;
    end else if (accept) begin
      last <= owner;
    end
  end

  always_comb begin
    winner = ARB_INST;
    unique case (1'b1)
      req_inst && req_data:  winner = ~last;
      req_data && !req_inst: winner = ARB_DATA;
      default:               winner = ARB_INST;
    endcase
  end
`else
  logic unused_sel;
  assign unused_sel = &{1'b0, clk, rst, accept, owner, req_inst};

  assign winner = req_data ? ARB_DATA : ARB_INST;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for a shared Avalon-style memory port.
// One transaction in flight; MEM_ARB_RR_EN selects round-robin arbitration.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_inst_addr,
  input  logic [BE_W-1:0]   i_inst_byte_en,
  input  logic [DATA_W-1:0] i_inst_writedata,
  input  logic              i_inst_read,
  input  logic              i_inst_write,
  output logic [DATA_W-1:0] o_inst_readdata,
  output logic              o_inst_readdata_valid,
  output logic              o_inst_waitrequest,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [BE_W-1:0]   i_data_byte_en,
  input  logic [DATA_W-1:0] i_data_writedata,
  input  logic              i_data_read,
  input  logic              i_data_write,
  output logic [DATA_W-1:0] o_data_readdata,
  output logic              o_data_readdata_valid,
  output logic              o_data_waitrequest,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [BE_W-1:0]   o_mem_byte_en,
  output logic [DATA_W-1:0] o_mem_writedata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_readdata,
  input  logic              i_mem_readdata_valid,
  input  logic              i_mem_waitrequest
);

  arb_state_t state, state_nx;
  logic       owner, owner_nx;
  logic       winner, accept;
  logic       req_i, req_d;
  logic       own_rd, own_wr;

  assign req_i = i_inst_read | i_inst_write;
  assign req_d = i_data_read | i_data_write;

  // Write wins if an owner illegally raises both strobes.
  assign own_wr = owner ? i_data_write : i_inst_write;
  assign own_rd = (owner ? i_data_read : i_inst_read) & ~own_wr;

  mem_arb_sel u_sel (
    .clk      (clk),
    .rst      (rst),
    .req_inst (req_i),
    .req_data (req_d),
    .accept   (accept),
    .owner    (owner),
    .winner   (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= ARB_INST;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end

  always_comb begin
    state_nx              = state;
    owner_nx              = owner;
    accept                = 1'b0;
    o_mem_addr            = '0;
    o_mem_byte_en         = '0;
    o_mem_writedata       = '0;
    o_mem_read            = 1'b0;
    o_mem_write           = 1'b0;
    o_inst_waitrequest    = 1'b1;
    o_data_waitrequest    = 1'b1;
    o_inst_readdata       = '0;
    o_data_readdata       = '0;
    o_inst_readdata_valid = 1'b0;
    o_data_readdata_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i || req_d) begin
          owner_nx = winner;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        o_mem_addr      = owner ? i_data_addr : i_inst_addr;
        o_mem_byte_en   = owner ? i_data_byte_en : i_inst_byte_en;
        o_mem_writedata = owner ? i_data_writedata
                                : i_inst_writedata;
        o_mem_read      = own_rd;
        o_mem_write     = own_wr;
        if (owner) o_data_waitrequest = i_mem_waitrequest;
        else       o_inst_waitrequest = i_mem_waitrequest;
        accept = (own_rd | own_wr) & ~i_mem_waitrequest;
        if (!(own_rd || own_wr)) begin
          state_nx = IDLE;
        end else if (accept) begin
          state_nx = own_wr ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (i_mem_readdata_valid) begin
          if (owner) begin
            o_data_readdata       = i_mem_readdata;
            o_data_readdata_valid = 1'b1;
          end else begin
            o_inst_readdata       = i_mem_readdata;
            o_inst_readdata_valid = 1'b1;
          end
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
